// File: rtl/fixed_point_mac_neuron.sv
// fixed_point_mac_neuron
//   Pipelined signed fixed-point multiply-accumulate neuron. It takes one
//   weight/pixel pair per cycle and accumulates N_INPUTS products plus a bias.
//   Once per frame it emits a result that is saturated and, optionally,
//   ReLU-rectified.
//   Pipeline: S1 multiply -> S2 saturating accumulate -> S3 relu/clamp/output.
// Ports
//   clk, GlobalReset   : rising-edge clock; asynchronous active-high reset
//   in_valid           : weight/pixel pair valid this cycle
//   weight             : sfix W_WIDTH, W_FRAC fraction bits
//   pixel              : signed integer, P_WIDTH bits
//   bias               : sfix OUT_WIDTH, W_FRAC fraction; taken with element 0
//   relu_en            : clamp negative result to 0; taken with the last element
//   clear              : synchronous abort of the current frame
//   out_valid          : one-cycle result strobe
//   out_data, out_sat  : result and its saturation flag (held until next result)
//   elem_cnt           : index of the next expected element
module fixed_point_mac_neuron #(
  parameter int W_WIDTH   = 19,
  parameter int W_FRAC    = 18,
  parameter int P_WIDTH   = 10,
  parameter int ACC_WIDTH = 36,
  parameter int OUT_WIDTH = 26,
  parameter int N_INPUTS  = 784,
  localparam int CNT_W    = $clog2(N_INPUTS)
) (
  input  logic                        clk,
  input  logic                        GlobalReset,
  input  logic                        in_valid,
  input  logic signed [W_WIDTH-1:0]   weight,
  input  logic signed [P_WIDTH-1:0]   pixel,
  input  logic signed [OUT_WIDTH-1:0] bias,
  input  logic                        relu_en,
  input  logic                        clear,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_sat,
  output logic [CNT_W-1:0]            elem_cnt
);
  localparam int PW = W_WIDTH + P_WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  // Elaboration guard: an illegal combination instantiates a module that does
  // not exist, so the build stops instead of silently truncating.
  if (ACC_WIDTH < PW || ACC_WIDTH < OUT_WIDTH || W_FRAC >= W_WIDTH || N_INPUTS < 2)
  begin : g_bad_params
    illegal_parameter_combination u_err ();
  end

  logic [2:1] vld_pipe;

  // ---------------- S1: multiply ----------------
  logic signed [PW-1:0]        prod_r;
  logic signed [OUT_WIDTH-1:0] bias1;
  logic                        first1, last1, relu1;

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      elem_cnt    <= '0;
      vld_pipe[1] <= 1'b0;
      prod_r      <= '0;
      bias1       <= '0;
      first1      <= 1'b0;
      last1       <= 1'b0;
      relu1       <= 1'b0;
    end else if (clear) begin
      elem_cnt    <= '0;
      vld_pipe[1] <= 1'b0;
    end else begin
      vld_pipe[1] <= in_valid;
      if (in_valid) begin
        prod_r   <= PW'(weight) * PW'(pixel);  // full-width, exact
        bias1    <= bias;
        relu1    <= relu_en;
        first1   <= (elem_cnt == '0);
        last1    <= (elem_cnt == LAST);
        elem_cnt <= (elem_cnt == LAST) ? '0 : elem_cnt + 1'b1;
      end
    end
  end

  // ---------------- S2: saturating accumulate ----------------
  logic signed [ACC_WIDTH-1:0] acc, add_a, sum_sat;
  logic signed [ACC_WIDTH:0]   sum;
  logic                        add_ovf, ovf, last2, relu2;

  always_comb begin
    // first element restarts the sum from the bias instead of the old acc
    add_a   = first1 ? ACC_WIDTH'(bias1) : acc;
    sum     = (ACC_WIDTH+1)'(add_a) + (ACC_WIDTH+1)'(prod_r);
    add_ovf = sum[ACC_WIDTH] != sum[ACC_WIDTH-1];
    sum_sat = add_ovf ? (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum[ACC_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      vld_pipe[2] <= 1'b0;
      acc         <= '0;
      ovf         <= 1'b0;
      last2       <= 1'b0;
      relu2       <= 1'b0;
    end else if (clear) begin
      vld_pipe[2] <= 1'b0;
    end else begin
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1]) begin
        acc   <= sum_sat;
        ovf   <= first1 ? add_ovf : (ovf | add_ovf);  // sticky within a frame
        last2 <= last1;
        relu2 <= relu1;
      end
    end
  end

  // ---------------- S3: relu, clamp, output ----------------
  logic signed [ACC_WIDTH-1:0] r;
  logic                        fits;
  logic signed [OUT_WIDTH-1:0] r_clamp;

  always_comb begin
    r       = (relu2 && acc[ACC_WIDTH-1]) ? '0 : acc;
    // fits in OUT_WIDTH when all bits above the output sign bit match it
    fits    = (&r[ACC_WIDTH-1:OUT_WIDTH-1]) | ~(|r[ACC_WIDTH-1:OUT_WIDTH-1]);
    r_clamp = fits ? r[OUT_WIDTH-1:0] : (r[ACC_WIDTH-1] ? OUT_MIN : OUT_MAX);
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= !clear && vld_pipe[2] && last2;
      if (!clear && vld_pipe[2] && last2) begin
        out_data <= r_clamp;
        out_sat  <= !fits || ovf;
      end
    end
  end

endmodule
